// File: rtl/qda_dac_serial_rx.sv
// -----------------------------------------------------------------------------
// qda_dac_serial_rx
//
// Receiving end of the QDA DAC serial load interface. It behaves like the DAC's
// own input shift/latch register and serves as an on-chip loopback checker.
//
// SIN, SCLK and PCLK are asynchronous to clk. All three pass through the same
// synchronizer chain, so SIN stays aligned with SCLK. Each SCLK rising edge
// shifts SIN in LSB-first. A PCLK rising edge latches the word into DATA_OUT,
// but only when exactly DATA_WIDTH bits have been shifted.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   SIN          serial data (async)
//   SCLK         shift clock (async), rising edge active
//   PCLK         latch strobe (async), rising edge active
//   DATA_OUT     last correctly received word
//   DATA_VALID   one-cycle pulse when DATA_OUT updates
//   FRAME_ERR    one-cycle pulse when PCLK arrives with bit count != DATA_WIDTH
//   TIMEOUT_ERR  one-cycle pulse when a partial frame is abandoned
//   BIT_COUNT    bits shifted in the current frame, saturating at DATA_WIDTH+1
//   FRAME_COUNT  good frames received, wraps at 16 bits
//
// Parameters:
//   DATA_WIDTH      bits per frame (2..30 so that BIT_COUNT can hold DATA_WIDTH+1)
//   SYNC_STAGES     synchronizer depth per line, at least 2
//   TIMEOUT_CYCLES  clk cycles without an SCLK/PCLK edge before a partial
//                   frame is dropped (1..65535)
//
// Minimum SCLK/PCLK high or low time is SYNC_STAGES+1 clk cycles.
// -----------------------------------------------------------------------------
module qda_dac_serial_rx #(
    parameter int DATA_WIDTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SIN,
    input  logic                  SCLK,
    input  logic                  PCLK,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_VALID,
    output logic                  FRAME_ERR,
    output logic                  TIMEOUT_ERR,
    output logic [4:0]            BIT_COUNT,
    output logic [15:0]           FRAME_COUNT
);

    localparam logic [4:0]  BC_FULL = 5'(DATA_WIDTH);
    localparam logic [4:0]  BC_SAT  = 5'(DATA_WIDTH + 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. The three lines are bundled into one 3-bit word
    // per stage ({PCLK, SCLK, SIN}), so every line sees the same delay.
    // ------------------------------------------------------------------
    logic [2:0]                   line_in;
    logic [SYNC_STAGES-1:0][2:0]  sync_reg;
    logic                         sin_s;
    logic                         sclk_s;
    logic                         pclk_s;

    assign line_in = {PCLK, SCLK, SIN};
    assign sin_s   = sync_reg[SYNC_STAGES-1][0];
    assign sclk_s  = sync_reg[SYNC_STAGES-1][1];
    assign pclk_s  = sync_reg[SYNC_STAGES-1][2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_in};
        end
    end

    // ------------------------------------------------------------------
    // Edge detection. The history flops remember the previous synchronized
    // level. The detected rise is registered together with a copy of SIN,
    // so the FSM sees the data bit in the same cycle as its SCLK edge. This
    // extra register is why DATA_VALID lands SYNC_STAGES+2 edges after the
    // PCLK pin rises.
    // ------------------------------------------------------------------
    logic sclk_prev_reg;
    logic pclk_prev_reg;
    logic sclk_rise_reg;
    logic pclk_rise_reg;
    logic sin_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_reg <= 1'b0;
            pclk_prev_reg <= 1'b0;
            sclk_rise_reg <= 1'b0;
            pclk_rise_reg <= 1'b0;
            sin_d_reg     <= 1'b0;
        end else begin
            sclk_prev_reg <= sclk_s;
            pclk_prev_reg <= pclk_s;
            sclk_rise_reg <= sclk_s & ~sclk_prev_reg;
            pclk_rise_reg <= pclk_s & ~pclk_prev_reg;
            sin_d_reg     <= sin_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM state and registered outputs
    // ------------------------------------------------------------------
    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   sr_reg;
    logic [4:0]              bit_count_reg;
    logic [15:0]             idle_cnt_reg;
    logic [DATA_WIDTH-1:0]   data_out_reg;
    logic                    data_valid_reg;
    logic                    frame_err_reg;
    logic                    timeout_err_reg;
    logic [15:0]             frame_count_reg;

    // The shift is applied before PCLK is evaluated. With a simultaneous
    // SCLK+PCLK rise, the latch decision therefore uses the post-shift count
    // and the post-shift register contents.
    logic [DATA_WIDTH-1:0]   sr_next;
    logic [4:0]              count_next;

    always_comb begin
        sr_next    = sr_reg;
        count_next = bit_count_reg;
        if (sclk_rise_reg) begin
            sr_next = {sin_d_reg, sr_reg[DATA_WIDTH-1:1]};
            if (bit_count_reg != BC_SAT) begin
                count_next = bit_count_reg + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            sr_reg          <= '0;
            bit_count_reg   <= '0;
            idle_cnt_reg    <= '0;
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            data_valid_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;

            if (pclk_rise_reg) begin
                // The latch strobe ends the frame in either state. In IDLE the
                // count is 0, so a lone PCLK is always a frame error.
                sr_reg        <= sr_next;
                bit_count_reg <= '0;
                idle_cnt_reg  <= '0;
                state_reg     <= IDLE;
                if (count_next == BC_FULL) begin
                    data_out_reg    <= sr_next;
                    data_valid_reg  <= 1'b1;
                    frame_count_reg <= frame_count_reg + 16'd1;
                end else begin
                    frame_err_reg <= 1'b1;
                end
            end else if (sclk_rise_reg) begin
                // After an overrun the register keeps shifting, so it holds
                // the most recent DATA_WIDTH bits.
                sr_reg        <= sr_next;
                bit_count_reg <= count_next;
                idle_cnt_reg  <= '0;
                state_reg     <= SHIFT;
            end else if (state_reg == SHIFT) begin
                if (idle_cnt_reg == TO_LAST) begin
                    timeout_err_reg <= 1'b1;
                    bit_count_reg   <= '0;
                    idle_cnt_reg    <= '0;
                    state_reg       <= IDLE;
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign DATA_OUT    = data_out_reg;
    assign DATA_VALID  = data_valid_reg;
    assign FRAME_ERR   = frame_err_reg;
    assign TIMEOUT_ERR = timeout_err_reg;
    assign BIT_COUNT   = bit_count_reg;
    assign FRAME_COUNT = frame_count_reg;

endmodule

// File: tb/tb_qda_dac_serial_rx.sv
// -----------------------------------------------------------------------------
// Testbench for qda_dac_serial_rx.
//
// Frames come from a table. Every PCLK pushes the expected event onto a
// scoreboard queue. A monitor pops the queue on every DATA_VALID, FRAME_ERR or
// TIMEOUT_ERR pulse and compares the pulse type, DATA_OUT and FRAME_COUNT.
// Hand-written sequences cover the timeout, a mid-frame reset, and a
// simultaneous SCLK/PCLK edge combined with FRAME_COUNT wrap.
// -----------------------------------------------------------------------------
module tb_qda_dac_serial_rx;

    localparam int DW = 16;
    localparam int SS = 2;
    localparam int TO = 100;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          SIN   = 1'b0;
    logic          SCLK  = 1'b0;
    logic          PCLK  = 1'b0;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_VALID;
    logic          FRAME_ERR;
    logic          TIMEOUT_ERR;
    logic [4:0]    BIT_COUNT;
    logic [15:0]   FRAME_COUNT;

    always #5 clk = ~clk;

    qda_dac_serial_rx #(
        .DATA_WIDTH     (DW),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SIN         (SIN),
        .SCLK        (SCLK),
        .PCLK        (PCLK),
        .DATA_OUT    (DATA_OUT),
        .DATA_VALID  (DATA_VALID),
        .FRAME_ERR   (FRAME_ERR),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .BIT_COUNT   (BIT_COUNT),
        .FRAME_COUNT (FRAME_COUNT)
    );

    int total = 0;
    int bad   = 0;

    // kind: 0 = DATA_VALID, 1 = FRAME_ERR, 2 = TIMEOUT_ERR
    typedef struct {
        int          kind;
        logic [15:0] data;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_data = 16'h0;
    logic [15:0] m_fc   = 16'h0;

    typedef struct {
        int          nbits;
        logic [31:0] data;
        logic [4:0]  exp_bc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit: SCLK low for 8 clocks, then high for 8 clocks.
    task automatic send_bit(input logic b);
        SIN  = b;
        SCLK = 1'b0;
        tick(8);
        SCLK = 1'b1;
        tick(8);
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) send_bit(data[i]);
    endtask

    // Update the reference model for one PCLK, and queue the event it must cause.
    task automatic expect_pclk(input int n, input logic [31:0] data);
        exp_t e;
        if (n == DW) begin
            m_data = data[15:0];
            m_fc   = m_fc + 16'd1;
            e.kind = 0;
        end else begin
            e.kind = 1;
        end
        e.data = m_data;
        e.fc   = m_fc;
        sb.push_back(e);
        $display("expect: bits=%0d kind=%0d data=0x%04h fc=0x%04h", n, e.kind, e.data, e.fc);
    endtask

    // Raise PCLK for 4 clocks and count the clk edges until a result pulse.
    task automatic pclk_and_measure(input string name);
        int lat;
        lat  = -1;
        PCLK = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (lat < 0 && (DATA_VALID || FRAME_ERR)) lat = k;
            if (k == 4) PCLK = 1'b0;
        end
        @(posedge clk);
        #1;
        chk(name, lat, SS + 2);
    endtask

    task automatic do_frame(input logic [31:0] data, input int n, input logic [4:0] exp_bc);
        send_bits(data, n);
        tick(4);
        @(negedge clk);
        chk("bit_count_before_pclk", BIT_COUNT, exp_bc);
        @(posedge clk);
        #1;
        expect_pclk(n, data);
        pclk_and_measure("pclk_latency");
        tick(2);
        @(negedge clk);
        chk("bit_count_after", BIT_COUNT, 0);
        chk("data_out_after", DATA_OUT, m_data);
        chk("frame_count_after", FRAME_COUNT, m_fc);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    int   mon_kind;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && (DATA_VALID || FRAME_ERR || TIMEOUT_ERR)) begin
            mon_kind = DATA_VALID ? 0 : (FRAME_ERR ? 1 : 2);
            chk("pulse_onehot", $countones({DATA_VALID, FRAME_ERR, TIMEOUT_ERR}), 1);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", mon_kind);
            end else begin
                mon_e = sb.pop_front();
                $display("event: kind=%0d data=0x%04h fc=0x%04h", mon_kind, DATA_OUT, FRAME_COUNT);
                chk("event_kind", mon_kind, mon_e.kind);
                chk("event_data", DATA_OUT, mon_e.data);
                chk("event_fc", FRAME_COUNT, mon_e.fc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [31:0] w;
        exp_t        te;

        vecs[0] = '{16, 32'h0000_A5C3, 5'd16};
        vecs[1] = '{8,  32'h0000_00FF, 5'd8};
        vecs[2] = '{0,  32'h0000_0000, 5'd0};
        vecs[3] = '{17, 32'h0001_FFFE, 5'd17};
        vecs[4] = '{16, 32'h0000_FFFF, 5'd16};
        vecs[5] = '{16, 32'h0000_8001, 5'd16};

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_data_out", DATA_OUT, 0);
        chk("rst_frame_count", FRAME_COUNT, 0);
        chk("rst_bit_count", BIT_COUNT, 0);
        chk("rst_pulses", {DATA_VALID, FRAME_ERR, TIMEOUT_ERR}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(4);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            do_frame(vecs[i].data, vecs[i].nbits, vecs[i].exp_bc);
        end

        // Timeout: 5 bits, then silence
        te.kind = 2;
        te.data = m_data;
        te.fc   = m_fc;
        sb.push_back(te);
        send_bits(32'h0000_0016, 4);
        SIN  = 1'b1;
        SCLK = 1'b0;
        tick(8);
        SCLK = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (BIT_COUNT == 5'd5) break;
        end
        chk("timeout_bc5", BIT_COUNT, 5);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            if (TIMEOUT_ERR) break;
        end
        chk("timeout_delay", cnt, TO);
        chk("timeout_bit_count", BIT_COUNT, 0);
        @(posedge clk);
        #1;
        do_frame(32'h0000_1234, 16, 5'd16);

        // Reset mid-frame, asserted between clk edges
        send_bits(32'h0000_0055, 7);
        #2;
        rst_n = 1'b0;
        SCLK  = 1'b0;
        PCLK  = 1'b0;
        #1;
        chk("midrst_data_out", DATA_OUT, 0);
        chk("midrst_frame_count", FRAME_COUNT, 0);
        chk("midrst_bit_count", BIT_COUNT, 0);
        m_data = 16'h0;
        m_fc   = 16'h0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick(4);
        do_frame(32'h0000_BEEF, 16, 5'd16);

        // Simultaneous 16th SCLK and PCLK rise, with FRAME_COUNT at 0xFFFF
        force dut.frame_count_reg = 16'hFFFF;
        tick(1);
        release dut.frame_count_reg;
        m_fc = 16'hFFFF;
        @(negedge clk);
        chk("preload_fc", FRAME_COUNT, 16'hFFFF);
        @(posedge clk);
        #1;
        w = 32'h0000_5A5A;
        send_bits(w, 15);
        SIN  = w[15];
        SCLK = 1'b0;
        tick(8);
        expect_pclk(16, w);
        SCLK = 1'b1;
        pclk_and_measure("simul_latency");
        tick(2);
        @(negedge clk);
        chk("simul_data_out", DATA_OUT, 16'h5A5A);
        chk("wrap_frame_count", FRAME_COUNT, 16'h0000);
        chk("simul_bit_count", BIT_COUNT, 0);

        tick(4);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qda_dac_serial_rx.md
Name: qda_dac_serial_rx

Overview:
- Receiving end of the QDA DAC serial load interface (SIN/SCLK/PCLK).
- Oversamples the three lines in the system clock domain and shifts SIN LSB-first on each SCLK rising edge.
- On a PCLK rising edge, transfers a complete word to a parallel output register, behaving like the DAC input shift/latch register.
- Used as the on-chip loopback checker and DAC bus model for frame verification and readback.

Parameters:
- DATA_WIDTH, 16, bits per frame; also the width of DATA_OUT.
- SYNC_STAGES, 2, synchronizer flops per input line (minimum 2).
- TIMEOUT_CYCLES, 65535, clk cycles without any SCLK/PCLK edge before a partial frame is aborted (legal range 1..65535).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- SIN  in  1  serial data, asynchronous to clk.
- SCLK  in  1  shift clock, asynchronous to clk.
- PCLK  in  1  latch/load strobe, asynchronous to clk.
- DATA_OUT  out  DATA_WIDTH  last correctly received word.
- DATA_VALID  out  1  one-cycle pulse when DATA_OUT updates.
- FRAME_ERR  out  1  one-cycle pulse when PCLK arrives with bit count != DATA_WIDTH.
- TIMEOUT_ERR  out  1  one-cycle pulse when a partial frame is aborted by timeout.
- BIT_COUNT  out  5  bits shifted in the current frame; saturates at DATA_WIDTH+1.
- FRAME_COUNT  out  16  good frames received; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset: all outputs, shift register, counters, synchronizers and edge-history flops go to 0; state = IDLE. Reset may assert at any time, including mid-frame, and discards any partial frame.
- Input capture:
  - SIN, SCLK and PCLK each pass through SYNC_STAGES flops, giving equal delay, so SIN stays aligned with SCLK.
  - An extra history flop per clock line provides rise detection (sync && !prev).
  - Minimum legal SCLK/PCLK high or low time is SYNC_STAGES+1 clk cycles.
- State IDLE: BIT_COUNT = 0.
  - An SCLK rise shifts in a bit, BIT_COUNT becomes 1, next state SHIFT.
  - A PCLK rise in IDLE pulses FRAME_ERR (count 0 != DATA_WIDTH).
- State SHIFT:
  - Each SCLK rise: sr <= {sin_sync, sr[DATA_WIDTH-1:1]}, so the first bit received lands in bit 0 after DATA_WIDTH shifts. BIT_COUNT increments, saturating at DATA_WIDTH+1.
  - Overrun (more than DATA_WIDTH shifts) keeps shifting, so the register holds the last DATA_WIDTH bits; the frame is still flagged bad at PCLK.
  - PCLK rise with BIT_COUNT == DATA_WIDTH: DATA_OUT <= sr, DATA_VALID = 1 for one cycle, FRAME_COUNT increments. Next state IDLE, BIT_COUNT cleared.
  - PCLK rise with any other BIT_COUNT: FRAME_ERR = 1 for one cycle, DATA_OUT and FRAME_COUNT unchanged. Next state IDLE, BIT_COUNT cleared.
- Timeout:
  - The idle counter runs only in SHIFT and clears on any SCLK or PCLK rise.
  - When the counter reaches TIMEOUT_CYCLES-1: TIMEOUT_ERR pulses, next state IDLE, BIT_COUNT cleared, DATA_OUT unchanged.
- Simultaneous SCLK and PCLK rise in the same cycle: the shift is applied first, then PCLK evaluates the updated count.
  - Example: 15 bits + simultaneous edge = 16 -> good frame, DATA_OUT includes the new bit.
- Latency: DATA_VALID asserts exactly SYNC_STAGES+2 clk edges after the PCLK pin rises; it is registered.
- SCLK falling edges and PCLK falling edges have no effect.

Test Plan:
- Good frame: with rst_n released, send 0xA5C3 LSB-first with an 8-clk SCLK low and 8-clk high period, then a 4-clk PCLK pulse. Required: DATA_OUT=0xA5C3, one DATA_VALID pulse SYNC_STAGES+2 cycles after PCLK rise, FRAME_COUNT=1, no error pulses.
- Short frame: send 8 bits then PCLK. Required: FRAME_ERR pulse, DATA_OUT keeps its prior value, FRAME_COUNT unchanged, BIT_COUNT=0 afterwards. Repeat with PCLK only (0 bits) and get the same result.
- Overrun: send 17 bits of 0x1_FFFE pattern (bit0=0, rest 1) then PCLK. Required: BIT_COUNT=17 before PCLK, FRAME_ERR pulse, no DATA_VALID.
- Timeout: with TIMEOUT_CYCLES=100, send 5 bits then stop. Required: TIMEOUT_ERR pulse 100 cycles after the 5th synchronized SCLK rise, BIT_COUNT=0. A following full frame 0x1234 gives DATA_OUT=0x1234.
- Reset mid-frame: assert rst_n=0 after 7 bits, for 3 cycles, asynchronously between clk edges. Required: outputs zero immediately, FRAME_COUNT=0. A subsequent frame 0xBEEF gives DATA_OUT=0xBEEF, FRAME_COUNT=1.
- Simultaneous edge and wrap: preload FRAME_COUNT to 0xFFFF via 65535 frames (or force), then send 15 bits and drive the 16th SCLK rise and PCLK rise together. Required: DATA_VALID pulse, FRAME_COUNT wraps to 0x0000.
